// File: rtl/uart_tx_core_if.sv
// Handshake and serial-line bundle between a UART transmit client and uart_tx_core.
// The master drives the request side; the core (slave) drives the line and status flags.
interface uart_tx_core_if;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       data_tx;
  logic       active_flag;
  logic       done_flag;

  modport master (
    output send,
    output data_in,
    output parity_type,
    output baud_rate,
    input  data_tx,
    input  active_flag,
    input  done_flag
  );

  modport slave (
    input  send,
    input  data_in,
    input  parity_type,
    input  baud_rate,
    output data_tx,
    output active_flag,
    output done_flag
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: fixed 11-bit frame (start, 8 data LSB first, parity slot, stop)
// at one of four baud rates derived from CLK_HZ by truncating integer division.
module uart_tx_core #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_core_if.slave bus
);

  localparam int MAX_DIV = CLK_HZ / 2400;
  localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Bit period minus one for each baud_rate code (2400 << code baud).
  logic [CNT_W-1:0] div_table [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_div
      localparam int DIV = CLK_HZ / (2400 << gi);
      assign div_table[gi] = CNT_W'(DIV - 1);
    end
  endgenerate

  state_t           state_reg;
  logic             tx_reg;
  logic             active_reg;
  logic             done_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] div_m1_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       data_reg;
  logic             parity_reg;

  logic             parity_next;
  logic             bit_end;
  logic [2:0]       bit_idx_next;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    parity_next = 1'b1;
    case (bus.parity_type)
      2'b01:   parity_next = ~^bus.data_in;
      2'b10:   parity_next = ^bus.data_in;
      default: parity_next = 1'b1;
    endcase
  end

  assign bit_end      = (cnt_reg == div_m1_reg);
  assign bit_idx_next = bit_idx_reg + 3'd1;
  assign cnt_next     = cnt_reg + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      tx_reg      <= 1'b1;
      active_reg  <= 1'b0;
      done_reg    <= 1'b0;
      cnt_reg     <= '0;
      div_m1_reg  <= '0;
      bit_idx_reg <= '0;
      data_reg    <= '0;
      parity_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.send) begin
            state_reg   <= START;
            tx_reg      <= 1'b0;
            active_reg  <= 1'b1;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            data_reg    <= bus.data_in;
            parity_reg  <= parity_next;
            div_m1_reg  <= div_table[bus.baud_rate];
          end
        end
        START: begin
          if (bit_end) begin
            state_reg <= DATA;
            tx_reg    <= data_reg[0];
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= PARITY;
              tx_reg    <= parity_reg;
            end else begin
              bit_idx_reg <= bit_idx_next;
              tx_reg      <= data_reg[bit_idx_next];
            end
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_reg <= STOP;
            tx_reg    <= 1'b1;
            cnt_reg   <= '0;
            // A one-clock stop bit is its own last cycle.
            if (div_m1_reg == '0) done_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_reg  <= IDLE;
            active_reg <= 1'b0;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_next;
            // Registered pulse lands on the final stop-bit clock.
            if (cnt_next == div_m1_reg) done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg  <= IDLE;
          tx_reg     <= 1'b1;
          active_reg <= 1'b0;
          cnt_reg    <= '0;
        end
      endcase
    end
  end

  assign bus.data_tx     = tx_reg;
  assign bus.active_flag = active_reg;
  assign bus.done_flag   = done_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// Randomized self-checking bench for uart_tx_core at CLK_HZ=192000 (DIV = 80/40/20/10).
// Each frame's waveform is compared against an ideal frame built from the protocol rules.
module tb_uart_tx_core;

  localparam int CLK_HZ = 192000;

  logic clock;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;

  uart_tx_core_if bus();

  uart_tx_core #(.CLK_HZ(CLK_HZ)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    vectors++;
    if (obs != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  function automatic int model_div(input logic [1:0] br);
    int baud;
    baud = 2400 * (1 << br);
    return CLK_HZ / baud;
  endfunction

  // Frame bit k is transmitted k-th: start, data LSB first, parity slot, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic [1:0] pt);
    logic [10:0] f;
    int          ones;
    logic        par;
    ones = $countones(d);
    if (pt == 2'b01)      par = ((ones % 2) == 0);
    else if (pt == 2'b10) par = ((ones % 2) == 1);
    else                  par = 1'b1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = par;
    f[10] = 1'b1;
    return f;
  endfunction

  // mode 0: single send pulse; 1: random send/input noise mid-frame;
  // 2: send held high, next frame's inputs presented at done (returns in the idle gap cycle).
  task automatic xmit(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] br,
                      input int mode, input logic [7:0] nd, input logic [1:0] npt,
                      input logic [1:0] nbr, output int start_cyc);
    int          div;
    int          total;
    int          n_end;
    int          tx_err;
    int          act_err;
    int          done_at;
    int          dones;
    logic [10:0] exp_frame;
    logic [10:0] obs_frame;
    logic        exp_tx;
    div       = model_div(br);
    total     = 11 * div;
    n_end     = (mode == 2) ? total + 1 : total + 3;
    exp_frame = model_frame(d, pt);
    obs_frame = '1;
    tx_err    = 0;
    act_err   = 0;
    done_at   = 0;
    dones     = 0;
    start_cyc = -1;
    bus.data_in     = d;
    bus.parity_type = pt;
    bus.baud_rate   = br;
    bus.send        = 1'b1;
    for (int n = 1; n <= n_end; n++) begin
      @(negedge clock);
      exp_tx = (n <= total) ? exp_frame[(n-1)/div] : 1'b1;
      if (bus.data_tx !== exp_tx) tx_err++;
      if (bus.active_flag !== (n <= total)) act_err++;
      if (bus.done_flag === 1'b1) begin
        dones++;
        if (done_at == 0) done_at = n;
      end
      if (start_cyc < 0 && bus.data_tx === 1'b0) start_cyc = cyc;
      if (n <= total && ((n-1) % div) == div / 2) obs_frame[(n-1)/div] = bus.data_tx;
      case (mode)
        1: begin
          if (n < total - 1) begin
            bus.send        = 1'($urandom_range(1));
            bus.data_in     = 8'($urandom);
            bus.parity_type = 2'($urandom_range(3));
            bus.baud_rate   = 2'($urandom_range(3));
          end else begin
            bus.send = 1'b0;
          end
        end
        2: begin
          if (n == total) begin
            bus.data_in     = nd;
            bus.parity_type = npt;
            bus.baud_rate   = nbr;
          end
        end
        default: bus.send = 1'b0;
      endcase
    end
    check_val("frame_bits", int'(obs_frame), int'(exp_frame));
    check_val("tx_wave_errs", tx_err, 0);
    check_val("active_errs", act_err, 0);
    check_val("done_at", done_at, total);
    check_val("done_count", dones, 1);
    $display("txn data=%02h parity=%0d baud=%0d mode=%0d div=%0d done_at=%0d",
             d, pt, br, mode, div, done_at);
  endtask

  initial begin
    int s1;
    int s2;
    int dones;
    int tx_hi_errs;
    int mode;
    vectors     = 0;
    miscompares = 0;

    // Send is held high during reset; the first accept must follow deassertion.
    reset           = 1'b1;
    bus.send        = 1'b1;
    bus.data_in     = 8'h3C;
    bus.parity_type = 2'b01;
    bus.baud_rate   = 2'b11;
    repeat (3) @(negedge clock);
    check_val("rst_data_tx", int'(bus.data_tx), 1);
    check_val("rst_active", int'(bus.active_flag), 0);
    check_val("rst_done", int'(bus.done_flag), 0);
    reset = 1'b0;
    xmit(8'h3C, 2'b01, 2'b11, 0, 8'h00, 2'b00, 2'b00, s1);

    xmit(8'hA5, 2'b10, 2'b11, 0, 8'h00, 2'b00, 2'b00, s1);
    xmit(8'h07, 2'b10, 2'b11, 0, 8'h00, 2'b00, 2'b00, s1);
    xmit(8'h07, 2'b01, 2'b11, 0, 8'h00, 2'b00, 2'b00, s1);
    xmit(8'hFF, 2'b00, 2'b00, 0, 8'h00, 2'b00, 2'b00, s1);
    xmit(8'h5A, 2'b10, 2'b10, 1, 8'h00, 2'b00, 2'b00, s1);

    xmit(8'h11, 2'b00, 2'b11, 2, 8'h22, 2'b00, 2'b11, s1);
    xmit(8'h22, 2'b00, 2'b11, 0, 8'h00, 2'b00, 2'b00, s2);
    check_val("b2b_start_gap", s2 - s1, 11 * model_div(2'b11) + 1);

    // Abort during data bit 4 (frame bit 5, samples 51..60 at DIV=10).
    bus.data_in     = 8'hC3;
    bus.parity_type = 2'b10;
    bus.baud_rate   = 2'b11;
    bus.send        = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    repeat (54) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_val("abort_data_tx", int'(bus.data_tx), 1);
    check_val("abort_active", int'(bus.active_flag), 0);
    check_val("abort_done", int'(bus.done_flag), 0);
    reset      = 1'b0;
    dones      = 0;
    tx_hi_errs = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (bus.done_flag === 1'b1) dones++;
      if (bus.data_tx !== 1'b1) tx_hi_errs++;
    end
    check_val("abort_no_done", dones, 0);
    check_val("abort_line_idle", tx_hi_errs, 0);
    $display("txn abort data=c3 reset in data bit 4");
    xmit(8'h81, 2'b00, 2'b10, 0, 8'h00, 2'b00, 2'b00, s1);

    for (int k = 0; k < 10; k++) begin
      mode = int'($urandom_range(1));
      xmit(8'($urandom), 2'($urandom_range(3)), 2'($urandom_range(3)), mode,
           8'h00, 2'b00, 2'b00, s1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the system clock frequency in Hz used to derive bit periods.
REQ-002 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port send  input  1  request to transmit data_in; accepted only when idle.
REQ-005 SHALL have port data_in  input  8  byte to transmit, sampled on accept.
REQ-006 SHALL have port parity_type  input  2  00 none, 01 odd, 10 even, 11 none; sampled on accept.
REQ-007 SHALL have port baud_rate  input  2  00 2400, 01 4800, 10 9600, 11 19200 baud; sampled on accept.
REQ-008 SHALL have port data_tx  output  1  serial line to the receiver, registered, idle high.
REQ-009 SHALL have port active_flag  output  1  high while a frame is in progress.
REQ-010 SHALL have port done_flag  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL always send an 11-bit frame, matching the receiver's fixed 11-bit SIPO: start (0), data bits 0..7 (LSB first), parity slot, stop (1).
REQ-012 SHALL drive the parity slot as follows: odd gives total ones in data plus parity odd; even gives total ones even; none (00/11) gives 1.
REQ-013 SHALL set bit period DIV = CLK_HZ / baud using integer division truncated, chosen by the baud_rate latched on accept; every frame bit lasts exactly DIV clocks.
REQ-014 SHALL use an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL transition IDLE->START when send=1 in IDLE; latch data_in, parity_type and baud_rate, load the bit counter, and compute parity.
REQ-016 SHALL transition START->DATA after DIV clocks, DATA->PARITY after 8xDIV clocks (3-bit index, LSB first), PARITY->STOP after DIV clocks, and STOP->IDLE after DIV clocks.
REQ-017 SHALL update data_tx on the clock following each state/bit change; data_tx SHALL fall to 0 on the first clock edge after the accept cycle.
REQ-018 SHALL hold active_flag=1 in every state except IDLE.
REQ-019 SHALL pulse done_flag=1 for exactly one cycle: the last clock of the stop-bit period, coincident with the STOP->IDLE transition.
REQ-020 SHALL ignore send while active_flag=1; ignored requests are not queued, and in-flight latched values are unaffected.
REQ-021 SHALL ignore changes on data_in, parity_type and baud_rate during a frame.
REQ-022 SHALL support back-to-back frames: send held high accepts a new frame in the first IDLE cycle after done_flag, with one idle-high cycle between the stop bit and the next start bit.
REQ-023 SHALL take the total frame length as 11xDIV clocks from the first data_tx=0 cycle to the done_flag cycle inclusive.
REQ-024 SHALL size the baud counter to hold CLK_HZ/2400 - 1 without overflow, and SHALL reload it to 0 at each bit boundary with no accumulated drift.

Reset
REQ-025 SHALL, while reset=1, force on the next edge: state IDLE, data_tx=1, active_flag=0, done_flag=0, counters 0, latched registers 0.
REQ-026 SHALL give reset priority over send and over any in-progress frame; a frame aborted mid-transmission SHALL NOT produce done_flag.
REQ-027 SHALL NOT accept send in a cycle where reset=1; the first accept is possible in the first cycle after reset deasserts.

Verification (CLK_HZ=192000, so DIV = 80/40/20/10)
REQ-028 SHALL cover: data_in=0xA5, parity_type=10, baud_rate=11, send pulse -> data_tx per 10-clk bit = 0,1,0,1,0,0,1,0,1,0,1; done_flag once, 110 clks after first low.
REQ-029 SHALL cover: data_in=0x07 with parity_type=10 then 01 -> parity slot 1 then 0, respectively.
REQ-030 SHALL cover: data_in=0xFF, parity_type=00, baud_rate=00 -> each bit 80 clks, parity slot 1, done after 880 clks; active_flag high throughout.
REQ-031 SHALL cover: send with 0x3C mid-frame of a 0x5A transmission -> serial output is 0x5A only, one done_flag, and no second frame.
REQ-032 SHALL cover: reset=1 during DATA bit 4 -> next edge data_tx=1, active_flag=0, and no done_flag; a following send of 0x81 transmits correctly.
REQ-033 SHALL cover: send held high with 0x11 then 0x22 -> two frames, start bits separated by 11xDIV+1 clks, two done_flag pulses.
